// File: rtl/shift_sequencer.sv
// shift_sequencer
// Serializes a parallel N-bit word one bit at a time. It does this by driving an
// external universal shift register: the block loads the register, then shifts it
// left or right, and presents the register's edge bit on a valid/ready serial port.
//
// Optional feature: when the macro SHIFT_SEQUENCER_WORD_COUNT_EN is defined, the
// block gets a 16-bit word_count output. It counts completed words and wraps
// at 0xFFFF. Without the macro the port and the counter do not exist.
module shift_sequencer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         msb_first,
  input  logic         flush,
  output logic         ser_data,
  output logic         ser_valid,
  input  logic         ser_ready,
  output logic         done,
  output logic [1:0]   usr_select,
  output logic         usr_enable,
  output logic [N-1:0] usr_data,
  input  logic [N-1:0] usr_q
`ifdef SHIFT_SEQUENCER_WORD_COUNT_EN
  ,
  output logic [15:0]  word_count
`endif
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);
  localparam logic [N-1:0]  MSB_TAP  = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]  LSB_TAP  = N'(1);

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_LEFT  = 2'b01;
  localparam logic [1:0] SEL_RIGHT = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    word_q, word_d;
  logic            msb_q, msb_d;
  logic [N-1:0]    tap_mask;

  // Registers for the FSM state, the bit counter and the captured word/order
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      msb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      msb_q   <= msb_d;
    end
  end

  // Next state, next holding values and all outputs, decoded from registered state.
  // The serial bit uses a one-hot tap mask, so the bit the shift register shifts
  // out is selected with an AND followed by an OR-reduce.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    msb_d      = msb_q;
    in_ready   = 1'b0;
    ser_valid  = 1'b0;
    ser_data   = 1'b0;
    done       = 1'b0;
    usr_select = SEL_HOLD;
    usr_enable = 1'b0;
    usr_data   = '0;
    tap_mask   = msb_q ? MSB_TAP : LSB_TAP;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_d  = in_data;
          msb_d   = msb_first;
          state_d = LOAD;
        end
      end

      LOAD: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          usr_select = SEL_LOAD;
          usr_enable = 1'b1;
          usr_data   = word_q;
          cnt_d      = '0;
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        ser_valid = 1'b1;
        ser_data  = |(usr_q & tap_mask);
        if (flush) begin
          state_d = IDLE;
        end else if (ser_ready) begin
          usr_enable = 1'b1;
          usr_select = msb_q ? SEL_LEFT : SEL_RIGHT;
          if (cnt_q == LAST_BIT) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef SHIFT_SEQUENCER_WORD_COUNT_EN
  logic [15:0] word_count_q, word_count_d;

  // Count each completed word; flushed words never reach DONE, so they are not counted
  always_comb begin
    word_count_d = word_count_q;
    if (state_q == DONE) begin
      word_count_d = word_count_q + 16'd1;
    end
  end

  // Completed-word counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_count_q <= '0;
    end else begin
      word_count_q <= word_count_d;
    end
  end

  assign word_count = word_count_q;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer
// Bench for shift_sequencer with N=8, connected to a behavioural universal shift
// register. Each stimulus call pushes the serial bits it expects, and the edge
// count at which it expects done, into queues. An independent monitor pops an
// entry from those queues whenever the DUT presents a taken bit or a done pulse.
// Define SHIFT_SEQUENCER_WORD_COUNT_EN to also check word_count.
module tb_shift_sequencer;

  localparam int N = 8;

  logic         clk;
  logic         reset;
  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         msb_first;
  logic         flush;
  logic         ser_data;
  logic         ser_valid;
  logic         ser_ready;
  logic         done;
  logic [1:0]   usr_select;
  logic         usr_enable;
  logic [N-1:0] usr_data;
  logic [N-1:0] usr_q;
`ifdef SHIFT_SEQUENCER_WORD_COUNT_EN
  logic [15:0]  word_count;
`endif

  int unsigned  edge_cnt;
  int           errors;
  int           checks;
  logic         exp_bits[$];
  int unsigned  exp_done[$];

  shift_sequencer #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .msb_first  (msb_first),
    .flush      (flush),
    .ser_data   (ser_data),
    .ser_valid  (ser_valid),
    .ser_ready  (ser_ready),
    .done       (done),
    .usr_select (usr_select),
    .usr_enable (usr_enable),
    .usr_data   (usr_data),
    .usr_q      (usr_q)
`ifdef SHIFT_SEQUENCER_WORD_COUNT_EN
    ,
    .word_count (word_count)
`endif
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts rising edges so that done timing can be checked against the accept edge
  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Universal shift register: hold, left/right shift with serial fill from usr_data, parallel load
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      usr_q <= '0;
    end else if (usr_enable) begin
      case (usr_select)
        2'b01:   usr_q <= {usr_q[N-2:0], usr_data[0]};
        2'b10:   usr_q <= {usr_data[N-1], usr_q[N-1:1]};
        2'b11:   usr_q <= usr_data;
        default: usr_q <= usr_q;
      endcase
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: compare every bit the downstream takes, and every done pulse, with the queues
  always @(negedge clk) begin
    if (!reset && ser_valid && ser_ready && !flush) begin
      if (exp_bits.size() == 0) begin
        check_output("unexpected_bit", 32'(ser_data), 32'hFFFF_FFFF);
      end else begin
        check_output("ser_data", 32'(ser_data), 32'(exp_bits.pop_front()));
      end
    end
    if (!reset && done) begin
      if (exp_done.size() == 0) begin
        check_output("unexpected_done", 32'd1, 32'd0);
      end else begin
        check_output("done_cycle", edge_cnt, exp_done.pop_front());
      end
    end
  end

  // Waits (bounded) for in_ready, then offers one word. Pushes the first nbits
  // serial bits it expects and, if want_done is set, the edge count at which done
  // must appear. Returns #1 after the accept edge.
  task automatic apply_stimulus(input logic [N-1:0] word, input logic msb, input int nbits,
                                input logic want_done, input int done_offset);
    int waited;
    int unsigned k;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!in_ready) check_output("in_ready_timeout", 32'd0, 32'd1);
    in_data   = word;
    msb_first = msb;
    in_valid  = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      exp_bits.push_back(msb ? word[N-1-i] : word[i]);
    end
    @(posedge clk);
    #1;
    k = edge_cnt;
    if (want_done) exp_done.push_back(k + done_offset - 1);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    msb_first = 1'b0;
    flush     = 1'b0;
    ser_ready = 1'b1;

    // Reset values
    #1;
    check_output("rst_in_ready", 32'(in_ready), 32'd1);
    check_output("rst_ser_valid", 32'(ser_valid), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_usr_enable", 32'(usr_enable), 32'd0);
    check_output("rst_usr_select", 32'(usr_select), 32'd0);
    check_output("rst_usr_data", 32'(usr_data), 32'd0);
`ifdef SHIFT_SEQUENCER_WORD_COUNT_EN
    check_output("rst_word_count", 32'(word_count), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // 0xC1 MSB first: 1,1,0,0,0,0,0,1 and done in cycle k+10
    apply_stimulus(8'hC1, 1'b1, 8, 1'b1, 10);
    check_output("load_ser_valid", 32'(ser_valid), 32'd0);
    check_output("load_in_ready", 32'(in_ready), 32'd0);
    check_output("load_usr_select", 32'(usr_select), 32'd3);
    check_output("load_usr_enable", 32'(usr_enable), 32'd1);
    check_output("load_usr_data", 32'(usr_data), 32'hC1);
    @(posedge clk);
    #1;
    check_output("first_bit_valid", 32'(ser_valid), 32'd1);
    check_output("first_bit_select", 32'(usr_select), 32'd1);
    check_output("first_bit_usr_data", 32'(usr_data), 32'd0);
    // A word offered while busy must be ignored
    in_data   = 8'hFF;
    msb_first = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;

    // 0xC1 LSB first: 1,0,0,0,0,0,1,1
    apply_stimulus(8'hC1, 1'b0, 8, 1'b1, 10);
    @(posedge clk);
    #1;
    check_output("lsb_select", 32'(usr_select), 32'd2);

    // 0xC1 MSB first with a 3-cycle stall on bit 3; done moves to k+13
    apply_stimulus(8'hC1, 1'b1, 8, 1'b1, 13);
    repeat (4) @(posedge clk);
    #1;
    ser_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("stall_ser_valid", 32'(ser_valid), 32'd1);
      check_output("stall_ser_data", 32'(ser_data), 32'd0);
      check_output("stall_usr_enable", 32'(usr_enable), 32'd0);
      check_output("stall_usr_select", 32'(usr_select), 32'd0);
      @(posedge clk);
    end
    #1;
    ser_ready = 1'b1;

    // Flush on the 4th bit: 3 bits taken, no done, back to IDLE next cycle
    apply_stimulus(8'hC1, 1'b1, 3, 1'b0, 0);
`ifdef SHIFT_SEQUENCER_WORD_COUNT_EN
    check_output("word_count_3", 32'(word_count), 32'd3);
`endif
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check_output("flush_usr_enable", 32'(usr_enable), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    check_output("flush_in_ready", 32'(in_ready), 32'd1);
    check_output("flush_ser_valid", 32'(ser_valid), 32'd0);
    check_output("flush_done", 32'(done), 32'd0);
`ifdef SHIFT_SEQUENCER_WORD_COUNT_EN
    check_output("word_count_flushed", 32'(word_count), 32'd3);
`endif

    // 0x5A MSB first after the flush: 0,1,0,1,1,0,1,0
    apply_stimulus(8'h5A, 1'b1, 8, 1'b1, 10);

    // Reset pulsed mid-SHIFT after two bits of 0x3C are taken
    apply_stimulus(8'h3C, 1'b1, 2, 1'b0, 0);
`ifdef SHIFT_SEQUENCER_WORD_COUNT_EN
    check_output("word_count_4", 32'(word_count), 32'd4);
`endif
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_output("midrst_in_ready", 32'(in_ready), 32'd1);
    check_output("midrst_ser_valid", 32'(ser_valid), 32'd0);
    check_output("midrst_done", 32'(done), 32'd0);
    check_output("midrst_usr_enable", 32'(usr_enable), 32'd0);
    check_output("midrst_usr_select", 32'(usr_select), 32'd0);
    check_output("midrst_usr_data", 32'(usr_data), 32'd0);
`ifdef SHIFT_SEQUENCER_WORD_COUNT_EN
    check_output("midrst_word_count", 32'(word_count), 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_output("postrst_in_ready", 32'(in_ready), 32'd1);

    // 0xA5 LSB first after reset: 1,0,1,0,0,1,0,1
    apply_stimulus(8'hA5, 1'b0, 8, 1'b1, 10);

    // Drain, bounded
    for (int i = 0; i < 40 && (exp_bits.size() != 0 || exp_done.size() != 0); i++) begin
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
    #1;
    check_output("bits_drained", 32'(exp_bits.size()), 32'd0);
    check_output("done_drained", 32'(exp_done.size()), 32'd0);
    check_output("final_in_ready", 32'(in_ready), 32'd1);
`ifdef SHIFT_SEQUENCER_WORD_COUNT_EN
    check_output("final_word_count", 32'(word_count), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
